// File: rtl/td4_sequencer_if.sv
// td4_sequencer_if -- program ROM bus between the TD4 sequencer and its ROM.
//   rom_addr : 4-bit instruction address (driven by the sequencer, equals pc)
//   rom_data : 8-bit instruction word, [7:4] opcode, [3:0] immediate
// master modport = sequencer side, slave modport = ROM side.
interface td4_sequencer_if;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/td4_sequencer.sv
// td4_sequencer -- 4-bit TD4-style CPU sequencer.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   run, step       : run continuously / single-step from IDLE
//   rom             : program ROM bus (rom_addr = pc, rom_data = instruction)
//   in_port         : external input read by IN A / IN B
//   out_port        : registered output written by OUT B / OUT Im
//   pc, reg_a/reg_b : program counter and general registers
//   carry           : carry flag from ADD
//   instr_done      : one-cycle pulse in the cycle after each retired EXEC
//   fault           : high while halted on an undefined opcode
// Parameter ILLEGAL_HALT: 1 = undefined opcode halts in FAULT, 0 = runs as NOP.
module td4_sequencer #(
    parameter int unsigned ILLEGAL_HALT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    td4_sequencer_if.master  rom,
    input  logic [3:0]       in_port,
    output logic [3:0]       out_port,
    output logic [3:0]       pc,
    output logic [3:0]       reg_a,
    output logic [3:0]       reg_b,
    output logic             carry,
    output logic             instr_done,
    output logic             fault
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_FAULT} state_e;

    state_e     state_q, state_d;
    logic [3:0] pc_q, pc_d, a_q, a_d, b_q, b_d, out_q, out_d;
    logic       carry_q, carry_d, done_q, done_d;
    logic [7:0] ir_q, ir_d;
    logic [3:0] op, im;
    logic [4:0] sum_a, sum_b;

    assign op    = ir_q[7:4];
    assign im    = ir_q[3:0];
    assign sum_a = {1'b0, a_q} + {1'b0, im};
    assign sum_b = {1'b0, b_q} + {1'b0, im};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            carry_q <= carry_d;
            done_q  <= done_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        carry_d = carry_q;
        ir_d    = ir_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE:  if (run || step) state_d = S_FETCH;
            S_FETCH: begin
                ir_d    = rom.rom_data;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // Common retire path; jumps override pc, ADD overrides carry.
                state_d = run ? S_FETCH : S_IDLE;
                pc_d    = pc_q + 4'd1;
                carry_d = 1'b0;
                done_d  = 1'b1;
                case (op)
                    4'b0000: {carry_d, a_d} = sum_a;
                    4'b0101: {carry_d, b_d} = sum_b;
                    4'b0011: a_d   = im;
                    4'b0111: b_d   = im;
                    4'b0001: a_d   = b_q;
                    4'b0100: b_d   = a_q;
                    4'b0010: a_d   = in_port;
                    4'b0110: b_d   = in_port;
                    4'b1001: out_d = b_q;
                    4'b1011: out_d = im;
                    4'b1111: pc_d  = im;
                    4'b1110: if (!carry_q) pc_d = im;
                    default: begin
                        // Only 1000/1010/1100/1101 reach here.
                        if (ILLEGAL_HALT != 0) begin
                            state_d = S_FAULT;
                            pc_d    = pc_q;
                            carry_d = carry_q;
                            done_d  = 1'b0;
                        end
                    end
                endcase
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    assign rom.rom_addr = pc_q;
    assign pc           = pc_q;
    assign reg_a        = a_q;
    assign reg_b        = b_q;
    assign out_port     = out_q;
    assign carry        = carry_q;
    assign instr_done   = done_q;
    assign fault        = (state_q == S_FAULT);

endmodule

// File: tb/tb_td4_sequencer.sv
// tb_td4_sequencer -- self-checking bench for td4_sequencer.
// dut0 uses ILLEGAL_HALT=1, dut1 uses ILLEGAL_HALT=0; both share clk/rst/in_port.
module tb_td4_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, run0, step0, run1, step1;
    logic [3:0] in_port;
    logic [7:0] rom0 [16];
    logic [7:0] rom1 [16];

    logic [3:0] out0, pc0, a0, b0, out1, pc1, a1, b1;
    logic       c0, done0, flt0, c1, done1, flt1;

    td4_sequencer_if if0();
    td4_sequencer_if if1();
    assign if0.rom_data = rom0[if0.rom_addr];
    assign if1.rom_data = rom1[if1.rom_addr];

    td4_sequencer #(.ILLEGAL_HALT(1)) dut0 (
        .clk(clk), .rst(rst), .run(run0), .step(step0), .rom(if0), .in_port(in_port),
        .out_port(out0), .pc(pc0), .reg_a(a0), .reg_b(b0), .carry(c0),
        .instr_done(done0), .fault(flt0));

    td4_sequencer #(.ILLEGAL_HALT(0)) dut1 (
        .clk(clk), .rst(rst), .run(run1), .step(step1), .rom(if1), .in_port(in_port),
        .out_port(out1), .pc(pc1), .reg_a(a1), .reg_b(b1), .carry(c1),
        .instr_done(done1), .fault(flt1));

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Architectural reference model (ISA level, no timing).
    logic [3:0] m_a, m_b, m_pc, m_out;
    logic       m_c;

    task automatic model_reset();
        m_a = 0; m_b = 0; m_pc = 0; m_out = 0; m_c = 0;
    endtask

    task automatic model_exec(input logic [7:0] ins, input logic [3:0] inp);
        logic [3:0] op, im;
        int s, npc;
        bit is_add;
        op = ins[7:4]; im = ins[3:0];
        s = 0; is_add = 0;
        npc = (int'(m_pc) + 1) % 16;
        case (op)
            4'h0: begin s = int'(m_a) + int'(im); m_a = 4'(s % 16); is_add = 1; end
            4'h5: begin s = int'(m_b) + int'(im); m_b = 4'(s % 16); is_add = 1; end
            4'h3: m_a = im;
            4'h7: m_b = im;
            4'h1: m_a = m_b;
            4'h4: m_b = m_a;
            4'h2: m_a = inp;
            4'h6: m_b = inp;
            4'h9: m_out = m_b;
            4'hB: m_out = im;
            4'hF: npc = int'(im);
            4'hE: if (m_c == 1'b0) npc = int'(im);
            default: ;
        endcase
        m_c  = is_add && (s > 15);
        m_pc = 4'(npc);
    endtask

    function automatic logic [7:0] rand_instr();
        logic [3:0] op;
        case ($urandom_range(0, 11))
            0: op = 4'h0;  1: op = 4'h5;  2: op = 4'h3;  3: op = 4'h7;
            4: op = 4'h1;  5: op = 4'h4;  6: op = 4'h2;  7: op = 4'h6;
            8: op = 4'h9;  9: op = 4'hB;  10: op = 4'hF; default: op = 4'hE;
        endcase
        return {op, 4'($urandom_range(0, 15))};
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic fill_rom(input bit which, input logic [7:0] v);
        for (int i = 0; i < 16; i++) begin
            if (which) rom1[i] = v; else rom0[i] = v;
        end
    endtask

    task automatic do_reset();
        rst = 1; run0 = 0; step0 = 0; run1 = 0; step1 = 0;
        tick(); tick();
        rst = 0;
        model_reset();
    endtask

    task automatic wait_done(input bit which, input int budget, output bit got, output int cyc);
        got = 0; cyc = 0;
        while (!got && cyc < budget) begin
            tick(); cyc++;
            if ((which ? done1 : done0) === 1'b1) got = 1;
        end
    endtask

    task automatic step_instr(input bit which, output bit got);
        int cyc;
        if (which) step1 = 1; else step0 = 1;
        tick();
        step0 = 0; step1 = 0;
        wait_done(which, 8, got, cyc);
    endtask

    task automatic test_reset();
        bit got; int cyc;
        fill_rom(0, 8'h00);
        rom0[0] = 8'h3A; rom0[1] = 8'h7C; rom0[2] = 8'hB6; rom0[3] = 8'h0F; rom0[4] = 8'hF4;
        do_reset();
        run0 = 1;
        for (int i = 0; i < 4; i++) wait_done(0, 10, got, cyc);
        chk_cnt++; if (got !== 1'b1) $display("FAIL rst_prerun_timeout got %b exp 1", got); else pass_cnt++;
        rst = 1; tick();
        chk_cnt++; if (pc0 !== 4'h0) $display("FAIL rst_pc got %h exp 0", pc0); else pass_cnt++;
        chk_cnt++; if (a0 !== 4'h0) $display("FAIL rst_a got %h exp 0", a0); else pass_cnt++;
        chk_cnt++; if (b0 !== 4'h0) $display("FAIL rst_b got %h exp 0", b0); else pass_cnt++;
        chk_cnt++; if (c0 !== 1'b0) $display("FAIL rst_carry got %b exp 0", c0); else pass_cnt++;
        chk_cnt++; if (out0 !== 4'h0) $display("FAIL rst_out got %h exp 0", out0); else pass_cnt++;
        chk_cnt++; if (done0 !== 1'b0) $display("FAIL rst_done got %b exp 0", done0); else pass_cnt++;
        chk_cnt++; if (flt0 !== 1'b0) $display("FAIL rst_fault got %b exp 0", flt0); else pass_cnt++;
        chk_cnt++; if (if0.rom_addr !== 4'h0) $display("FAIL rst_rom_addr got %h exp 0", if0.rom_addr); else pass_cnt++;
        rst = 0; run0 = 0;
    endtask

    task automatic test_program();
        bit got, stuck; int cyc;
        logic [7:0] prog [7];
        prog = '{8'h70, 8'h20, 8'h01, 8'h01, 8'h40, 8'h90, 8'hF6};
        fill_rom(0, 8'h00);
        for (int i = 0; i < 7; i++) rom0[i] = prog[i];
        do_reset();
        in_port = 4'h3; run0 = 1;
        for (int i = 0; i < 7; i++) begin
            wait_done(0, 10, got, cyc);
            chk_cnt++; if (got !== 1'b1) $display("FAIL prog_done_%0d timeout", i); else pass_cnt++;
            if (i > 0) begin
                chk_cnt++; if (cyc != 2) $display("FAIL prog_rate_%0d got %0d cycles exp 2", i, cyc); else pass_cnt++;
            end
        end
        chk_cnt++; if (b0 !== 4'h5) $display("FAIL prog_b got %h exp 5", b0); else pass_cnt++;
        chk_cnt++; if (out0 !== 4'h5) $display("FAIL prog_out got %h exp 5", out0); else pass_cnt++;
        chk_cnt++; if (a0 !== 4'h5) $display("FAIL prog_a got %h exp 5", a0); else pass_cnt++;
        chk_cnt++; if (pc0 !== 4'h6) $display("FAIL prog_pc got %h exp 6", pc0); else pass_cnt++;
        tick();
        chk_cnt++; if (done0 !== 1'b0) $display("FAIL prog_pulse_width got %b exp 0", done0); else pass_cnt++;
        stuck = 1;
        for (int i = 0; i < 20; i++) begin tick(); if (pc0 !== 4'h6) stuck = 0; end
        chk_cnt++; if (stuck !== 1'b1) $display("FAIL prog_pc_hold got %h exp 6", pc0); else pass_cnt++;
        run0 = 0;
    endtask

    task automatic test_carry_jnc();
        bit got;
        fill_rom(0, 8'h00);
        rom0[0] = 8'h3F; rom0[1] = 8'h01; rom0[2] = 8'hE0; rom0[3] = 8'hE9;
        do_reset();
        step_instr(0, got);
        chk_cnt++; if ({got, a0, c0} !== {1'b1, 4'hF, 1'b0}) $display("FAIL jnc_setup got a=%h c=%b exp a=f c=0", a0, c0); else pass_cnt++;
        step_instr(0, got);
        chk_cnt++; if ({got, a0, c0} !== {1'b1, 4'h0, 1'b1}) $display("FAIL add_carry got a=%h c=%b exp a=0 c=1", a0, c0); else pass_cnt++;
        step_instr(0, got);
        chk_cnt++; if ({got, pc0, c0} !== {1'b1, 4'h3, 1'b0}) $display("FAIL jnc_not_taken got pc=%h c=%b exp pc=3 c=0", pc0, c0); else pass_cnt++;
        step_instr(0, got);
        chk_cnt++; if ({got, pc0} !== {1'b1, 4'h9}) $display("FAIL jnc_taken got pc=%h exp 9", pc0); else pass_cnt++;
    endtask

    task automatic test_wrap();
        bit got;
        fill_rom(0, 8'h00);
        rom0[0] = 8'hFF; rom0[15] = 8'h37;
        do_reset();
        step_instr(0, got);
        chk_cnt++; if ({got, pc0} !== {1'b1, 4'hF}) $display("FAIL wrap_jmp got pc=%h exp f", pc0); else pass_cnt++;
        step_instr(0, got);
        chk_cnt++; if ({got, pc0, a0} !== {1'b1, 4'h0, 4'h7}) $display("FAIL wrap got pc=%h a=%h exp pc=0 a=7", pc0, a0); else pass_cnt++;
    endtask

    task automatic test_step();
        int n;
        fill_rom(0, 8'h05);
        do_reset();
        for (int k = 1; k <= 2; k++) begin
            n = 0;
            step0 = 1; tick(); step0 = 0;
            for (int i = 0; i < 12; i++) begin tick(); if (done0 === 1'b1) n++; end
            chk_cnt++; if (n != 1) $display("FAIL step_pulses_%0d got %0d exp 1", k, n); else pass_cnt++;
            chk_cnt++; if ({pc0, a0} !== {4'(k), 4'(5 * k)}) $display("FAIL step_state_%0d got pc=%h a=%h exp pc=%h a=%h", k, pc0, a0, 4'(k), 4'(5 * k)); else pass_cnt++;
        end
    endtask

    task automatic test_illegal();
        bit got, any_done; int cyc;
        fill_rom(0, 8'h00);
        rom0[0] = 8'h3F; rom0[1] = 8'h01; rom0[2] = 8'h80;
        do_reset();
        run0 = 1;
        wait_done(0, 10, got, cyc);
        wait_done(0, 10, got, cyc);
        chk_cnt++; if (got !== 1'b1) $display("FAIL halt_prerun timeout"); else pass_cnt++;
        any_done = 0;
        for (int i = 0; i < 14; i++) begin
            if (i == 7) step0 = 1;
            tick();
            if (done0 === 1'b1) any_done = 1;
        end
        step0 = 0;
        chk_cnt++; if (flt0 !== 1'b1) $display("FAIL halt_fault got %b exp 1", flt0); else pass_cnt++;
        chk_cnt++; if (any_done !== 1'b0) $display("FAIL halt_no_done got %b exp 0", any_done); else pass_cnt++;
        chk_cnt++; if ({pc0, a0, c0} !== {4'h2, 4'h0, 1'b1}) $display("FAIL halt_state got pc=%h a=%h c=%b exp pc=2 a=0 c=1", pc0, a0, c0); else pass_cnt++;
        run0 = 0;
        do_reset();
        chk_cnt++; if (flt0 !== 1'b0) $display("FAIL halt_clear got %b exp 0", flt0); else pass_cnt++;

        fill_rom(1, 8'h00);
        rom1[0] = 8'h3F; rom1[1] = 8'h01; rom1[2] = 8'h80;
        do_reset();
        step_instr(1, got);
        step_instr(1, got);
        chk_cnt++; if (c1 !== 1'b1) $display("FAIL nop_setup got c=%b exp 1", c1); else pass_cnt++;
        step_instr(1, got);
        chk_cnt++; if (got !== 1'b1) $display("FAIL nop_done timeout"); else pass_cnt++;
        chk_cnt++; if ({pc1, c1, flt1, a1, b1, out1} !== {4'h3, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0})
            $display("FAIL nop_state got pc=%h c=%b f=%b a=%h b=%h o=%h exp pc=3 c=0 f=0 a=0 b=0 o=0", pc1, c1, flt1, a1, b1, out1); else pass_cnt++;
    endtask

    task automatic test_rst_mid_exec();
        bit got, quiet;
        fill_rom(0, 8'h00);
        rom0[0] = 8'h34; rom0[1] = 8'h01;
        do_reset();
        step_instr(0, got);
        chk_cnt++; if ({got, a0, pc0} !== {1'b1, 4'h4, 4'h1}) $display("FAIL midrst_setup got a=%h pc=%h exp a=4 pc=1", a0, pc0); else pass_cnt++;
        step0 = 1; tick(); step0 = 0;   // -> FETCH
        tick();                         // -> EXEC of ADD A,1
        rst = 1; tick(); rst = 0;
        chk_cnt++; if ({a0, pc0, c0, done0} !== {4'h0, 4'h0, 1'b0, 1'b0}) $display("FAIL midrst got a=%h pc=%h c=%b d=%b exp all 0", a0, pc0, c0, done0); else pass_cnt++;
        quiet = 1;
        for (int i = 0; i < 6; i++) begin tick(); if (done0 === 1'b1 || pc0 !== 4'h0) quiet = 0; end
        chk_cnt++; if (quiet !== 1'b1) $display("FAIL midrst_idle got pc=%h exp 0 and no done", pc0); else pass_cnt++;
        model_reset();
    endtask

    task automatic test_random_step();
        bit got;
        for (int i = 0; i < 16; i++) rom0[i] = rand_instr();
        do_reset();
        for (int n = 0; n < 40; n++) begin
            in_port = 4'($urandom_range(0, 15));
            model_exec(rom0[m_pc], in_port);
            step_instr(0, got);
            chk_cnt++;
            if ({got, a0, b0, c0, pc0, out0} !== {1'b1, m_a, m_b, m_c, m_pc, m_out})
                $display("FAIL rnd_step_%0d got a=%h b=%h c=%b pc=%h o=%h exp a=%h b=%h c=%b pc=%h o=%h",
                         n, a0, b0, c0, pc0, out0, m_a, m_b, m_c, m_pc, m_out);
            else pass_cnt++;
        end
    endtask

    task automatic test_random_run();
        bit got; int cyc, n;
        for (int i = 0; i < 16; i++) rom0[i] = rand_instr();
        do_reset();
        in_port = 4'($urandom_range(0, 15));
        run0 = 1;
        for (int k = 0; k < 30; k++) begin
            model_exec(rom0[m_pc], in_port);
            wait_done(0, 10, got, cyc);
            chk_cnt++;
            if ({got, a0, b0, c0, pc0, out0} !== {1'b1, m_a, m_b, m_c, m_pc, m_out})
                $display("FAIL rnd_run_%0d got a=%h b=%h c=%b pc=%h o=%h exp a=%h b=%h c=%b pc=%h o=%h",
                         k, a0, b0, c0, pc0, out0, m_a, m_b, m_c, m_pc, m_out);
            else pass_cnt++;
        end
        // Now in FETCH: dropping run must still retire this instruction, then stop.
        run0 = 0;
        model_exec(rom0[m_pc], in_port);
        n = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (done0 === 1'b1) n++; end
        chk_cnt++; if (n != 1) $display("FAIL run_drop_pulses got %0d exp 1", n); else pass_cnt++;
        chk_cnt++; if ({a0, b0, c0, pc0, out0} !== {m_a, m_b, m_c, m_pc, m_out})
            $display("FAIL run_drop_state got pc=%h exp %h", pc0, m_pc); else pass_cnt++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1; run0 = 0; step0 = 0; run1 = 0; step1 = 0; in_port = 0;
        fill_rom(0, 8'h00);
        fill_rom(1, 8'h00);
        model_reset();
        test_reset();
        test_program();
        test_carry_jnc();
        test_wrap();
        test_step();
        test_illegal();
        test_rst_mid_exec();
        test_random_step();
        test_random_run();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/td4_sequencer.md
TD4_SEQUENCER -- requirements
Module: td4_sequencer

Interface
REQ-001 SHALL have parameter ILLEGAL_HALT, default 1, meaning 1 = undefined opcode enters FAULT, 0 = undefined opcode executes as NOP.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port run  input  1  level; 1 = execute instructions continuously.
REQ-005 SHALL have port step  input  1  level sampled in IDLE; 1 with run=0 = execute exactly one instruction.
REQ-006 SHALL have port rom_addr  output  4  instruction address to program ROM.
REQ-007 SHALL have port rom_data  input  8  instruction from ROM: [7:4] opcode, [3:0] immediate.
REQ-008 SHALL have port in_port  input  4  external input, sampled by IN.
REQ-009 SHALL have port out_port  output  4  registered output port.
REQ-010 SHALL have port pc  output  4  program counter.
REQ-011 SHALL have port reg_a / reg_b  output  4 each  general registers A and B.
REQ-012 SHALL have port carry  output  1  carry flag.
REQ-013 SHALL have port instr_done  output  1  one-cycle pulse per retired instruction.
REQ-014 SHALL have port fault  output  1  high while in FAULT state.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, EXEC, FAULT.
REQ-016 SHALL drive rom_addr = pc combinationally at all times.
REQ-017 IDLE SHALL go to FETCH when run=1 or step=1; otherwise stay in IDLE.
REQ-018 FETCH SHALL latch rom_data into a 8-bit instruction register and go to EXEC.
REQ-019 EXEC SHALL execute the latched instruction; the next state SHALL be FETCH if run=1, else IDLE (FAULT overrides).
REQ-020 Throughput SHALL be 2 cycles per instruction in run mode; instr_done SHALL be high in the cycle after EXEC.
REQ-021 Opcodes SHALL be: 0000 ADD A,Im; 0101 ADD B,Im; 0011 MOV A,Im; 0111 MOV B,Im; 0001 MOV A,B; 0100 MOV B,A; 0010 IN A; 0110 IN B; 1001 OUT B; 1011 OUT Im; 1111 JMP Im; 1110 JNC Im.
REQ-022 ADD SHALL compute a 5-bit sum; reg gets sum[3:0], carry gets sum[4].
REQ-023 Every non-ADD instruction, including jumps and NOP, SHALL clear carry to 0 at EXEC.
REQ-024 JNC SHALL load pc=Im when carry=0 at EXEC, else pc+1; JMP SHALL always load pc=Im.
REQ-025 Non-jump instructions SHALL set pc=pc+1, modulo 16 (15 wraps to 0).
REQ-026 IN SHALL sample in_port during the EXEC cycle.
REQ-027 out_port SHALL change only on OUT B / OUT Im and otherwise hold.
REQ-028 Undefined opcodes (1000, 1010, 1100, 1101) with ILLEGAL_HALT=1 SHALL enter FAULT with pc, registers and carry unchanged and no instr_done.
REQ-029 Undefined opcodes with ILLEGAL_HALT=0 SHALL act as NOP: pc+1, carry cleared, instr_done pulsed.
REQ-030 FAULT SHALL persist regardless of run/step until rst.
REQ-031 Deasserting run during FETCH SHALL still complete the current instruction, then go to IDLE.

Reset
REQ-032 rst SHALL take priority over all other inputs in any state, including mid-EXEC.
REQ-033 On rst: state=IDLE; pc=0, reg_a=0, reg_b=0, carry=0, out_port=0, instruction register=0, instr_done=0, fault=0.
REQ-034 An instruction interrupted by rst SHALL have no architectural effect.

Verification
REQ-035 Program {70,20,01,01,40,90,F6}, in_port=3, run=1 after reset -> after 7 instr_done pulses: B=5, out_port=5, A=5, pc=6; pc stays 6 thereafter.
REQ-036 A=F, carry=0, then ADD A,1 followed by JNC 0 at pc=k -> A=0, carry=1; JNC not taken, pc=k+2; next instruction clears carry.
REQ-037 pc=15 holding MOV A,7 -> pc wraps to 0, A=7.
REQ-038 run=0, step held 1 for one IDLE cycle -> exactly one instr_done, FSM returns to IDLE, pc advances by 1.
REQ-039 rom_data=80 with ILLEGAL_HALT=1 -> fault=1, pc unchanged, no further execution until rst; same with ILLEGAL_HALT=0 -> pc+1, fault=0.
REQ-040 rst asserted during EXEC of ADD A,1 with A=4 -> next cycle A=0, pc=0, carry=0, IDLE.
